// File: rtl/clk_monitor_pkg.sv
// Shared state encoding and default counter width for the clock monitor.
package clk_monitor_pkg;

    localparam int unsigned COUNTER_BITS_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2,
        DONE       = 2'd3
    } state_t;

endpackage

// File: rtl/edge_sampler.sv
// Two-flop level sampler of the monitored clock with rising/falling edge strobes.
module edge_sampler (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_in,
    output logic s1,
    output logic s2,
    output logic rise_c,
    output logic fall_c
);

    // Sample the monitored clock level and keep one cycle of history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= tick_in;
            s2 <= s1;
        end
    end

    assign rise_c = s1 & ~s2;
    assign fall_c = ~s1 & s2;

endmodule

// File: rtl/clk_monitor.sv
// Counts delivered processor cycles and measures period / high time of the divided clock.
module clk_monitor #(
    parameter int unsigned COUNTER_BITS = clk_monitor_pkg::COUNTER_BITS_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    tick_in,
    input  logic                    start,
    input  logic                    clear,
    input  logic [COUNTER_BITS-1:0] target,
    input  logic [COUNTER_BITS-1:0] timeout,
    output logic                    busy,
    output logic                    done,
    output logic                    stalled,
    output logic                    overflow,
    output logic [COUNTER_BITS-1:0] cycle_count,
    output logic [COUNTER_BITS-1:0] period,
    output logic [COUNTER_BITS-1:0] high_time,
    output logic                    period_valid
);
    import clk_monitor_pkg::*;

    localparam int unsigned CW = COUNTER_BITS;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic s1, s2, rise_c, fall_c;

    state_t        state_q, state_d;
    logic [CW-1:0] target_q, target_d;
    logic [CW-1:0] timeout_q, timeout_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic [CW-1:0] period_cnt_q, period_cnt_d;
    logic [CW-1:0] high_cnt_q, high_cnt_d;
    logic [CW-1:0] cycle_count_d, period_d, high_time_d;
    logic          period_valid_d, stalled_d, overflow_d, done_d, busy_d;
    logic [CW-1:0] cc_inc_c, idle_inc_c;
    logic          timeout_hit_c;

    edge_sampler u_edge_sampler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_in (tick_in),
        .s1      (s1),
        .s2      (s2),
        .rise_c  (rise_c),
        .fall_c  (fall_c)
    );

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    assign cc_inc_c      = cycle_count + CW'(1);
    assign idle_inc_c    = idle_cnt_q + CW'(1);
    assign timeout_hit_c = (timeout_q != '0) && (idle_inc_c == timeout_q);

    // Next-state and counter update; clear beats start, start beats edges, edges beat timeout.
    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        timeout_d      = timeout_q;
        idle_cnt_d     = idle_cnt_q;
        period_cnt_d   = period_cnt_q;
        high_cnt_d     = high_cnt_q;
        cycle_count_d  = cycle_count;
        period_d       = period;
        high_time_d    = high_time;
        period_valid_d = period_valid;
        stalled_d      = stalled;
        overflow_d     = overflow;
        done_d         = 1'b0;

        if (clear || start) begin
            state_d        = clear ? IDLE : WAIT_FIRST;
            if (!clear) begin
                target_d  = target;
                timeout_d = timeout;
            end
            idle_cnt_d     = '0;
            period_cnt_d   = '0;
            high_cnt_d     = '0;
            cycle_count_d  = '0;
            period_d       = '0;
            high_time_d    = '0;
            period_valid_d = 1'b0;
            stalled_d      = 1'b0;
            overflow_d     = 1'b0;
        end else begin
            unique case (state_q)
                WAIT_FIRST: begin
                    if (rise_c) begin
                        state_d       = MEASURE;
                        cycle_count_d = CW'(1);
                        period_cnt_d  = CW'(1);
                        high_cnt_d    = CW'(1);
                        idle_cnt_d    = '0;
                        if (target_q == CW'(1)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else if (timeout_hit_c) begin
                        state_d   = IDLE;
                        stalled_d = 1'b1;
                    end else begin
                        idle_cnt_d = sat_inc(idle_cnt_q);
                    end
                end
                MEASURE: begin
                    if (s1 && s2) high_cnt_d = sat_inc(high_cnt_q);
                    if (fall_c) high_time_d = high_cnt_q;
                    if (rise_c) begin
                        cycle_count_d  = cc_inc_c;
                        if (cc_inc_c == '0) overflow_d = 1'b1;
                        period_d       = period_cnt_q;
                        period_valid_d = 1'b1;
                        period_cnt_d   = CW'(1);
                        high_cnt_d     = CW'(1);
                        idle_cnt_d     = '0;
                        if ((target_q != '0) && (cc_inc_c == target_q)) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        period_cnt_d = sat_inc(period_cnt_q);
                        if (timeout_hit_c) begin
                            state_d   = IDLE;
                            stalled_d = 1'b1;
                        end else begin
                            idle_cnt_d = sat_inc(idle_cnt_q);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end

        busy_d = (state_d == WAIT_FIRST) || (state_d == MEASURE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            target_q     <= '0;
            timeout_q    <= '0;
            idle_cnt_q   <= '0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            cycle_count  <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            stalled      <= 1'b0;
            overflow     <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            timeout_q    <= timeout_d;
            idle_cnt_q   <= idle_cnt_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            cycle_count  <= cycle_count_d;
            period       <= period_d;
            high_time    <= high_time_d;
            period_valid <= period_valid_d;
            stalled      <= stalled_d;
            overflow     <= overflow_d;
            done         <= done_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_clk_monitor.sv
// Scoreboard bench for clk_monitor at a 4-bit counter width.
module tb_clk_monitor;

    localparam int unsigned CB = 4;

    logic          clk = 1'b0;
    logic          reset_n, tick_in, start, clear;
    logic [CB-1:0] target, timeout;
    logic          busy, done, stalled, overflow, period_valid;
    logic [CB-1:0] cycle_count, period, high_time;

    typedef struct {
        int cc; int per; int ht; int pv; int st; int ov; int bz; int dn;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   dones    = 0;
    bit   busy_prev = 1'b0;
    bit   ended     = 1'b0;
    bit   gen_en    = 1'b0;
    int   hi_len = 2, lo_len = 2, phase = 0, pulses_left = -1;
    int   waited;

    always #5 clk = ~clk;

    clk_monitor #(.COUNTER_BITS(CB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick_in      (tick_in),
        .start        (start),
        .clear        (clear),
        .target       (target),
        .timeout      (timeout),
        .busy         (busy),
        .done         (done),
        .stalled      (stalled),
        .overflow     (overflow),
        .cycle_count  (cycle_count),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One system clock: sample outputs at the falling edge, then drive the tick pattern.
    task automatic cycle();
        @(negedge clk);
        if (done) dones++;
        if (busy_prev && !busy) ended = 1'b1;
        busy_prev = busy;
        if (gen_en) begin
            if (phase == 0 && pulses_left == 0) begin
                gen_en  = 1'b0;
                tick_in = 1'b0;
            end else begin
                tick_in = (phase < hi_len);
                if (phase == 0 && pulses_left > 0) pulses_left--;
                phase = (phase + 1) % (hi_len + lo_len);
            end
        end
    endtask

    task automatic start_gen(input int h, input int l, input int n);
        hi_len = h; lo_len = l; phase = 0; pulses_left = n; gen_en = 1'b1;
    endtask

    task automatic stop_gen();
        gen_en = 1'b0; tick_in = 1'b0;
    endtask

    task automatic do_start(input int tgt, input int tmo);
        target = CB'(tgt); timeout = CB'(tmo);
        start = 1'b1; ended = 1'b0; dones = 0;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        ended = 1'b0;
    endtask

    task automatic push(input int cc, input int per, input int ht, input int pv,
                        input int st, input int ov, input int bz, input int dn);
        exp_t e;
        e.cc = cc; e.per = per; e.ht = ht; e.pv = pv;
        e.st = st; e.ov = ov; e.bz = bz; e.dn = dn;
        sb_q.push_back(e);
    endtask

    task automatic wait_end(input string tag, input int budget, output int n);
        n = 0;
        while (!ended && n < budget) begin
            cycle();
            n++;
        end
        check({tag, ".ended"}, int'(ended), 1);
        ended = 1'b0;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        check({tag, ".sb_nonempty"}, (sb_q.size() > 0) ? 1 : 0, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, ".cycle_count"},  int'(cycle_count),  e.cc);
            check({tag, ".period"},       int'(period),       e.per);
            check({tag, ".high_time"},    int'(high_time),    e.ht);
            check({tag, ".period_valid"}, int'(period_valid), e.pv);
            check({tag, ".stalled"},      int'(stalled),      e.st);
            check({tag, ".overflow"},     int'(overflow),     e.ov);
            check({tag, ".busy"},         int'(busy),         e.bz);
            check({tag, ".dones"},        dones,              e.dn);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; tick_in = 1'b0; start = 1'b0; clear = 1'b0;
        target = '0; timeout = '0;
        repeat (2) cycle();
        push(0, 0, 0, 0, 0, 0, 0, 0);
        compare_out("reset");
        reset_n = 1'b1;
        repeat (2) cycle();

        // Counted measurement with 2 high / 2 low.
        push(5, 4, 2, 1, 0, 0, 0, 1);
        do_start(5, 0);
        start_gen(2, 2, -1);
        wait_end("t1", 60, waited);
        compare_out("t1");
        stop_gen();
        repeat (4) cycle();
        check("t1.done_once", dones, 1);

        // Free-run wrap at 4 bits: 17 rises.
        push(1, 4, 2, 1, 0, 1, 1, 0);
        do_start(0, 0);
        start_gen(2, 2, 17);
        for (int i = 0; i < 100 && gen_en; i++) cycle();
        repeat (4) cycle();
        compare_out("t2");
        do_clear();

        // Stall in WAIT_FIRST after exactly 10 clocks.
        push(0, 0, 0, 0, 1, 0, 0, 0);
        do_start(0, 10);
        repeat (9) cycle();
        check("t3.stalled_early", int'(stalled), 0);
        check("t3.busy_early", int'(busy), 1);
        wait_end("t3", 5, waited);
        check("t3.latency", waited, 1);
        compare_out("t3");

        // start together with clear in MEASURE.
        do_start(0, 0);
        start_gen(2, 2, -1);
        for (int i = 0; i < 40 && cycle_count != CB'(3); i++) cycle();
        check("t4.reach3", int'(cycle_count), 3);
        push(0, 0, 0, 0, 0, 0, 0, 0);
        clear = 1'b1; start = 1'b1;
        cycle();
        clear = 1'b0; start = 1'b0;
        stop_gen();
        wait_end("t4", 3, waited);
        compare_out("t4");
        repeat (3) cycle();

        // Restart coincident with a rise: that edge is not counted.
        do_start(0, 0);
        tick_in = 1'b1; cycle(); cycle();
        check("t5.pre_cc", int'(cycle_count), 1);
        tick_in = 1'b0; cycle(); cycle();
        tick_in = 1'b1; cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("t5.restart_cc", int'(cycle_count), 0);
        check("t5.restart_busy", int'(busy), 1);
        tick_in = 1'b0; cycle(); cycle();
        tick_in = 1'b1; cycle(); cycle();
        check("t5.next_cc", int'(cycle_count), 1);
        tick_in = 1'b0;
        do_clear();
        repeat (3) cycle();

        // target == 1: done on first rise, no period.
        push(1, 0, 0, 0, 0, 0, 0, 1);
        do_start(1, 0);
        start_gen(2, 2, -1);
        wait_end("t6", 30, waited);
        compare_out("t6");
        stop_gen();
        repeat (3) cycle();

        // Rise coincides with timeout match: edge wins.
        push(3, 4, 1, 1, 0, 0, 0, 1);
        do_start(3, 4);
        start_gen(1, 3, -1);
        wait_end("t7", 40, waited);
        compare_out("t7");
        stop_gen();
        repeat (3) cycle();

        // Period counter saturates at all-ones.
        push(2, 15, 2, 1, 0, 0, 0, 1);
        do_start(2, 0);
        start_gen(2, 18, -1);
        wait_end("t8", 80, waited);
        compare_out("t8");
        stop_gen();
        repeat (3) cycle();

        // Asynchronous reset mid-measurement, then a fresh 3/3 measurement.
        do_start(0, 0);
        start_gen(3, 3, -1);
        repeat (20) cycle();
        check("t9.pre_pv", int'(period_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        check("t9.rst_cc", int'(cycle_count), 0);
        check("t9.rst_period", int'(period), 0);
        check("t9.rst_pv", int'(period_valid), 0);
        check("t9.rst_busy", int'(busy), 0);
        stop_gen();
        cycle();
        reset_n = 1'b1;
        busy_prev = 1'b0; ended = 1'b0;
        repeat (2) cycle();
        push(3, 6, 3, 1, 0, 0, 0, 1);
        do_start(3, 0);
        start_gen(3, 3, -1);
        wait_end("t9", 60, waited);
        compare_out("t9");
        stop_gen();
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
